mem_arbiter: RTL

//  - Shares the single memIO port (f_memwrite/memaddr/writedata/readdata) between two requesters:
//    m0 = CPU load/store, m1 = mandelbrot pixel writer.
//  - Round-robin arbitration, one access per cycle, read-return tagging.
//  - Optional built-in screen-clear sequencer that fills screen memory with one code.
//  - Sits between the requesters and memIO; its mem_* outputs drive memIO directly.

---
 rtl/mem_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares the single memIO port between two requesters (m0 = CPU load/store,
//   m1 = mandelbrot pixel writer). Round-robin, one access per cycle, with
//   read-return tagging. An optional screen-clear sequencer fills screen memory
//   with one code word; it is built only when MEM_ARB_CLEAR_EN is defined.
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   mX_req/we/addr/wdata        requester X access (held until mX_gnt)
//   mX_gnt                      access accepted this cycle (combinational)
//   mX_rvalid/rdata             read data return, cycle after a granted read
//   clear_start, clear_code     start a screen clear with the given code
//   clear_busy, clear_done      clear in progress / one-cycle completion pulse
//   mem_we/addr/wdata           drive memIO f_memwrite/memaddr/writedata
//   mem_rdata                   memIO readdata, valid one cycle after address
//
// States (MEM_ARB_CLEAR_EN only)
//   state | meaning
//   IDLE  | normal round-robin arbitration
//   CLEAR | one screen write per cycle, requesters blocked
//   DONE  | clear_done pulse, requesters still blocked

module mem_arbiter #(
  parameter logic [31:0] SCREEN_BASE  = 32'h0000_4000,
  parameter int          SCREEN_WORDS = 2048
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  input  logic        clear_start,
  input  logic [7:0]  clear_code,
  output logic        clear_busy,
  output logic        clear_done,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  // last_gnt: 0 = m0 granted last, 1 = m1 granted last
  logic        last_gnt;
  logic        arb_en;
  logic        clr_wr;
  logic [31:0] clr_addr;
  logic [31:0] clr_wdata;

`ifdef MEM_ARB_CLEAR_EN
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CLEAR = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam int CW = (SCREEN_WORDS > 1) ? $clog2(SCREEN_WORDS) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(SCREEN_WORDS - 1);

  logic [1:0]    state;
  logic [CW-1:0] count;
  logic [7:0]    code;

  // A clear_start seen in IDLE is taken even if a request is granted in the
  // same cycle; the sweep itself starts on the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      code  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clear_start) begin
            state <= CLEAR;
            count <= '0;
            code  <= clear_code;
          end
        end
        CLEAR: begin
          count <= count + 1'b1;
          if (count == LAST_IDX) begin
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign arb_en     = (state == IDLE);
  assign clr_wr     = (state == CLEAR);
  assign clr_addr   = SCREEN_BASE + 32'(count);
  assign clr_wdata  = {24'b0, code};
  assign clear_busy = (state != IDLE);
  assign clear_done = (state == DONE);
`else
  wire unused_clear = ^{clear_start, clear_code};

  assign arb_en     = 1'b1;
  assign clr_wr     = 1'b0;
  assign clr_addr   = '0;
  assign clr_wdata  = '0;
  assign clear_busy = 1'b0;
  assign clear_done = 1'b0;
`endif

  // On a tie the requester that was not served last wins.
  assign m0_gnt = arb_en & m0_req & (~m1_req | last_gnt);
  assign m1_gnt = arb_en & m1_req & (~m0_req | ~last_gnt);

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (clr_wr) begin
      mem_we    = 1'b1;
      mem_addr  = clr_addr;
      mem_wdata = clr_wdata;
    end else if (m0_gnt) begin
      mem_we    = m0_we;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
    end else if (m1_gnt) begin
      mem_we    = m1_we;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt  <= 1'b1;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
    end else begin
      m0_rvalid <= m0_gnt & ~m0_we;
      m1_rvalid <= m1_gnt & ~m1_we;
      if (m0_gnt) begin
        last_gnt <= 1'b0;
      end else if (m1_gnt) begin
        last_gnt <= 1'b1;
      end
    end
  end

  // memIO returns data one cycle after the address; the rvalid tag says whose.
  assign m0_rdata = mem_rdata;
  assign m1_rdata = mem_rdata;

endmodule
